// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
// Module : store_pkg
// Brief  : Shared definitions for the store path: store-size encodings,
//          store FSM state encoding and the byte-offset width helper.
// Rev    : 1.0  initial release
// ============================================================================
package store_pkg;

  // Store size encodings as presented by the control unit
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Number of byte-offset bits inside one memory word (log2 of bytes/word)
  function automatic int ofs_bits(input int data_w);
    return (data_w == 64) ? 3 : 2;
  endfunction

endpackage : store_pkg
`default_nettype wire

// File: rtl/byte_lane_merge.sv
`default_nettype none
// ============================================================================
// Module : byte_lane_merge
// Brief  : Combinational byte-lane merger. Places the low bytes of new_data
//          into old_word starting at byte lane ofs (little-endian); all other
//          lanes pass through. Word size replaces the whole word.
// Ports  : old_word_i  word read back from memory
//          new_data_i  store source data (low bytes used for half/byte)
//          size_i      store size encoding (store_pkg SZ_*)
//          ofs_i       starting byte lane
//          merged_o    merged word
// Rev    : 1.0  initial release
// ============================================================================
module byte_lane_merge
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           old_word_i,
  input  logic [DATA_W-1:0]           new_data_i,
  input  logic [1:0]                  size_i,
  input  logic [ofs_bits(DATA_W)-1:0] ofs_i,
  output logic [DATA_W-1:0]           merged_o
);

  localparam int NB = DATA_W / 8;

  always_comb begin
    merged_o = old_word_i;
    for (int b = 0; b < NB; b++) begin
      case (size_i)
        SZ_WORD: merged_o[b*8 +: 8] = new_data_i[b*8 +: 8];
        SZ_HALF: begin
          // A half that would run past the top lane is misaligned upstream
          if (b == int'(ofs_i))          merged_o[b*8 +: 8] = new_data_i[7:0];
          else if (b == int'(ofs_i) + 1) merged_o[b*8 +: 8] = new_data_i[15:8];
        end
        SZ_BYTE: begin
          if (b == int'(ofs_i)) merged_o[b*8 +: 8] = new_data_i[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule : byte_lane_merge
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module : store_merge_unit
// Brief  : Sequential store path. Word stores are written directly; half and
//          byte stores read the aligned word, merge the new bytes into their
//          lanes and write the word back. Misaligned or reserved-size
//          requests are aborted with a one-cycle misalign_err pulse.
// Ports  : clk_i, reset_n_i           clock / async active-low reset
//          start_i                    request strobe (sampled in IDLE only)
//          store_size_i, addr_i,
//          b_data_i                   request size, byte address, source data
//          mem_rdata_i                memory read data (MEM_LAT after mem_rd)
//          mem_addr_o, mem_rd_o,
//          mem_wr_o, mem_wdata_o      memory interface
//          busy_o, done_o,
//          misalign_err_o             status
// Rev    : 1.0  initial release
// ============================================================================
module store_merge_unit
  import store_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [1:0]        store_size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              misalign_err_o
);

  localparam int OFS   = ofs_bits(DATA_W);
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  state_e              state_q, state_d;
  logic [1:0]          size_q;
  logic [OFS-1:0]      ofs_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [OFS-1:0]      ofs_in;
  logic                req_err;
  logic [DATA_W-1:0]   merged;

  assign ofs_in = addr_i[OFS-1:0];

  // Alignment check on the request being captured; the same values are
  // latched on this edge, so it is equivalent to checking the latched copy.
  always_comb begin
    req_err = 1'b0;
    case (store_size_i)
      SZ_WORD: req_err = (ofs_in != '0);
      SZ_HALF: req_err = addr_i[0];
      SZ_BYTE: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (req_err)                    state_d = ST_ERR;
          else if (store_size_i == SZ_WORD) state_d = ST_WR;
          else                            state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_WR;
      ST_WR:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      size_q     <= '0;
      ofs_q      <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            size_q <= store_size_i;
            ofs_q  <= ofs_in;
            data_q <= b_data_i;
            // Aborted requests never reach the bus, so mem_addr keeps the
            // address of the last real access.
            if (!req_err) mem_addr_q <= {addr_i[ADDR_W-1:OFS], {OFS{1'b0}}};
          end
        end
        ST_RD:   cnt_q <= CNT_W'(MEM_LAT);
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) rdata_q <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  byte_lane_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .old_word_i (rdata_q),
    .new_data_i (data_q),
    .size_i     (size_q),
    .ofs_i      (ofs_q),
    .merged_o   (merged)
  );

  // Strobes decode straight from the state so an async reset drops them at once
  assign busy_o         = (state_q != ST_IDLE);
  assign mem_rd_o       = (state_q == ST_RD);
  assign mem_wr_o       = (state_q == ST_WR);
  assign done_o         = (state_q == ST_WR);
  assign misalign_err_o = (state_q == ST_ERR);
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = (state_q == ST_WR) ? merged : '0;

endmodule : store_merge_unit
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_store_merge_unit
// Brief  : Self-checking bench for store_merge_unit. Three instances:
//          0 = 32-bit / MEM_LAT 1, 1 = 32-bit / MEM_LAT 3, 2 = 64-bit / MEM_LAT 1.
// Rev    : 1.0  initial release
// ============================================================================
module tb_store_merge_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1, start2;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [63:0] bdata, rdata;

  logic        rd0, wr0, dn0, er0, bz0;
  logic        rd1, wr1, dn1, er1, bz1;
  logic        rd2, wr2, dn2, er2, bz2;
  logic [31:0] ma0, ma1, ma2;
  logic [31:0] wd0, wd1;
  logic [63:0] wd2;

  int checks = 0;
  int errors = 0;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u_dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start0), .store_size_i(size),
    .addr_i(addr), .b_data_i(bdata[31:0]), .mem_rdata_i(rdata[31:0]),
    .mem_addr_o(ma0), .mem_rd_o(rd0), .mem_wr_o(wr0), .mem_wdata_o(wd0),
    .busy_o(bz0), .done_o(dn0), .misalign_err_o(er0));

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start1), .store_size_i(size),
    .addr_i(addr), .b_data_i(bdata[31:0]), .mem_rdata_i(rdata[31:0]),
    .mem_addr_o(ma1), .mem_rd_o(rd1), .mem_wr_o(wr1), .mem_wdata_o(wd1),
    .busy_o(bz1), .done_o(dn1), .misalign_err_o(er1));

  store_merge_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(1)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start2), .store_size_i(size),
    .addr_i(addr), .b_data_i(bdata), .mem_rdata_i(rdata),
    .mem_addr_o(ma2), .mem_rd_o(rd2), .mem_wr_o(wr2), .mem_wdata_o(wd2),
    .busy_o(bz2), .done_o(dn2), .misalign_err_o(er2));

  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : 1;
  endfunction

  function automatic int dw_of(input int s);
    return (s == 2) ? 64 : 32;
  endfunction

  // ---------------- reference model (plain arithmetic on the rules) -------
  function automatic bit model_err(input int dw, input logic [1:0] sz, input logic [31:0] a);
    int ofs = int'(a % (dw / 8));
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b00) return (ofs != 0);
    if (sz == 2'b01) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_wdata(input int dw, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [63:0] b,
                                              input logic [63:0] old);
    int nb = dw / 8;
    int ofs = int'(a % nb);
    int n = (sz == 2'b00) ? nb : (sz == 2'b01) ? 2 : 1;
    logic [63:0] lane, mask, res, wmask;
    lane  = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    wmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mask  = lane << (8 * ofs);
    res   = (old & ~mask) | ((b & lane) << (8 * ofs));
    return res & wmask;
  endfunction

  function automatic logic [31:0] model_addr(input int dw, input logic [31:0] a);
    return a & ~(32'(dw / 8) - 32'd1);
  endfunction

  // ---------------- helpers -----------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic get_out(input int s, output logic rd, output logic wr, output logic dn,
                         output logic er, output logic bz, output logic [31:0] ma,
                         output logic [63:0] wd);
    case (s)
      0:       begin rd = rd0; wr = wr0; dn = dn0; er = er0; bz = bz0; ma = ma0; wd = {32'h0, wd0}; end
      1:       begin rd = rd1; wr = wr1; dn = dn1; er = er1; bz = bz1; ma = ma1; wd = {32'h0, wd1}; end
      default: begin rd = rd2; wr = wr2; dn = dn2; er = er2; bz = bz2; ma = ma2; wd = wd2; end
    endcase
  endtask

  task automatic set_start(input int s, input logic v);
    start0 = (s == 0) ? v : 1'b0;
    start1 = (s == 1) ? v : 1'b0;
    start2 = (s == 2) ? v : 1'b0;
  endtask

  // One store request on instance s; memory answers exactly MEM_LAT after mem_rd.
  task automatic run_txn(input string tag, input int s, input logic [1:0] sz,
                         input logic [31:0] a, input logic [63:0] b, input logic [63:0] old,
                         input bit hold, input bit e_err, input logic [63:0] e_wd,
                         input logic [31:0] e_ma);
    int L = lat_of(s);
    int t_rd = -1, t_wr = -1, t_er = -1, n_rd = 0, n_wr = 0;
    bit fin = 1'b0, bad = 1'b0;
    logic rd, wr, dn, er, bz;
    logic [31:0] ma, a_rd, a_wr;
    logic [63:0] wd, wd_wr;
    a_rd = '0; a_wr = '0; wd_wr = '0;
    @(negedge clk);
    size = sz; addr = a; bdata = b; rdata = {$urandom, $urandom};
    set_start(s, 1'b1);
    for (int c = 1; c <= 30 && !fin; c++) begin
      @(negedge clk);
      if (!hold) set_start(s, 1'b0);
      get_out(s, rd, wr, dn, er, bz, ma, wd);
      if (dn !== wr || (dn && er)) bad = 1'b1;
      if (!bz) bad = 1'b1;
      if (rd) begin n_rd++; if (t_rd < 0) begin t_rd = c; a_rd = ma; end end
      if (wr) begin n_wr++; t_wr = c; a_wr = ma; wd_wr = wd; fin = 1'b1; end
      if (er) begin t_er = c; fin = 1'b1; end
      if (fin) set_start(s, 1'b0);
      rdata = (t_rd > 0 && c == t_rd + L) ? old : {$urandom, $urandom};
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done or misalign_err within 30 cycles", tag);
    end
    chk({tag, " status_consistent"}, 64'(bad), 64'd0);
    if (e_err) begin
      chk({tag, " err_cycle"}, 64'(t_er), 64'd1);
      chk({tag, " no_rd"}, 64'(n_rd), 64'd0);
      chk({tag, " no_wr"}, 64'(n_wr), 64'd0);
    end else if (sz == 2'b00) begin
      chk({tag, " wr_cycle"}, 64'(t_wr), 64'd1);
      chk({tag, " no_rd"}, 64'(n_rd), 64'd0);
      chk({tag, " wr_addr"}, 64'(a_wr), 64'(e_ma));
      chk({tag, " wdata"}, wd_wr, e_wd);
    end else begin
      chk({tag, " rd_cycle"}, 64'(t_rd), 64'd1);
      chk({tag, " rd_addr"}, 64'(a_rd), 64'(e_ma));
      chk({tag, " wr_cycle"}, 64'(t_wr), 64'(2 + L));
      chk({tag, " wr_addr"}, 64'(a_wr), 64'(e_ma));
      chk({tag, " wdata"}, wd_wr, e_wd);
    end
    @(negedge clk);
    get_out(s, rd, wr, dn, er, bz, ma, wd);
    chk({tag, " idle_after"}, {61'd0, bz, wr, er}, 64'd0);
  endtask

  typedef struct {
    int          s;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [63:0] b;
    logic [63:0] old;
    bit          hold;
    bit          e_err;
    logic [63:0] e_wd;
    logic [31:0] e_ma;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic rd, wr, dn, er, bz;
    logic [31:0] ma;
    logic [63:0] wd;
    int bad;

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    size = '0; addr = '0; bdata = '0; rdata = '0;

    vt[0] = '{0, 2'b00, 32'h100, 64'hDEADBEEF, 64'h0, 1'b0, 1'b0, 64'hDEADBEEF, 32'h100};
    vt[1] = '{0, 2'b10, 32'h203, 64'h000000AB, 64'h11223344, 1'b0, 1'b0, 64'hAB223344, 32'h200};
    vt[2] = '{1, 2'b01, 32'h302, 64'h0000CAFE, 64'h11223344, 1'b0, 1'b0, 64'hCAFE3344, 32'h300};
    vt[3] = '{0, 2'b00, 32'h101, 64'h12345678, 64'h0, 1'b0, 1'b1, 64'h0, 32'h0};
    vt[4] = '{0, 2'b01, 32'h103, 64'h12345678, 64'h0, 1'b0, 1'b1, 64'h0, 32'h0};
    vt[5] = '{0, 2'b11, 32'h100, 64'h12345678, 64'h0, 1'b0, 1'b1, 64'h0, 32'h0};
    vt[6] = '{2, 2'b10, 32'h7, 64'hFFFFFFFF_FFFFFF5A, 64'h01234567_89ABCDEF, 1'b1, 1'b0,
              64'h5A234567_89ABCDEF, 32'h0};
    vt[7] = '{2, 2'b01, 32'h2A, 64'h00000000_00001234, 64'h0, 1'b1, 1'b0,
              64'h00000000_12340000, 32'h28};

    // Reset state of every instance
    #12;
    for (int s = 0; s < 3; s++) begin
      get_out(s, rd, wr, dn, er, bz, ma, wd);
      chk($sformatf("reset_outputs_%0d", s), {ma, wd[25:0], rd, wr, dn, er, bz, 1'b0}, 64'd0);
      chk($sformatf("reset_wdata_%0d", s), wd, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vt[i].s, vt[i].sz, vt[i].a, vt[i].b, vt[i].old,
              vt[i].hold, vt[i].e_err, vt[i].e_wd, vt[i].e_ma);

    // Randomized requests against the model
    for (int i = 0; i < 45; i++) begin
      int s;
      logic [1:0] sz;
      logic [31:0] a;
      logic [63:0] b, old;
      bit hold;
      s = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      b = {$urandom, $urandom};
      old = {$urandom, $urandom};
      hold = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", i), s, sz, a, b, old, hold,
              model_err(dw_of(s), sz, a), model_wdata(dw_of(s), sz, a, b, old),
              model_addr(dw_of(s), a));
    end

    // Asynchronous reset in the middle of WAIT (instance 1, MEM_LAT 3)
    @(negedge clk);
    size = 2'b10; addr = 32'h203; bdata = 64'hAB;
    set_start(1, 1'b1);
    @(negedge clk);
    set_start(1, 1'b0);
    @(negedge clk);
    get_out(1, rd, wr, dn, er, bz, ma, wd);
    chk("midwait_busy_before_reset", 64'(bz), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    get_out(1, rd, wr, dn, er, bz, ma, wd);
    chk("midwait_strobes_cleared", {59'd0, rd, wr, dn, er, bz}, 64'd0);
    chk("midwait_addr_cleared", 64'(ma), 64'd0);
    chk("midwait_wdata_cleared", wd, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      get_out(1, rd, wr, dn, er, bz, ma, wd);
      if (wr || bz || rd || dn || er) bad++;
    end
    chk("after_reset_idle_no_write", 64'(bad), 64'd0);

    // Unit still works after the reset
    run_txn("post_reset", 1, 2'b01, 32'h302, 64'h0000CAFE, 64'h11223344, 1'b0, 1'b0,
            64'hCAFE3344, 32'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_store_merge_unit
`default_nettype wire
